// File: rtl/ftdi_tx_writer.sv
// FT245-style asynchronous byte write path: splits 16-bit readback words into two
// bytes (low first) and strobes FWR whenever the synchronised FTXE reports space.
module ftdi_tx_writer #(
  parameter int SETUP_CYCLES    = 1,
  parameter int WR_PULSE_CYCLES = 3,
  parameter int HOLD_CYCLES     = 1,
  parameter int GAP_CYCLES      = 4
) (
  input  logic        CLK48M,
  input  logic        RESET,
  input  logic        enable,
  input  logic [15:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        FTXE,
  output logic [7:0]  FU_D_out,
  output logic        FU_D_oe,
  output logic        FWR,
  output logic        busy,
  output logic [31:0] byte_count
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);
  // The cycle that loads the gap timer already counts as the first gap cycle.
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_TXE = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t      state;
  logic        txe_meta;
  logic        txe_s;
  logic [15:0] word_reg;
  logic        byte_sel;
  logic [3:0]  phase_cnt;
  logic [7:0]  gap_cnt;
  logic        accept;

  assign accept = word_valid & word_ready;

  // FTXE synchroniser; resets to "full" so nothing is written before it settles.
  always_ff @(posedge CLK48M or negedge RESET) begin
    if (!RESET) begin
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
    end else begin
      txe_meta <= FTXE;
      txe_s    <= txe_meta;
    end
  end

  // Write sequencer with its gap timer and the running byte counter.
  always_ff @(posedge CLK48M or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      word_reg   <= 16'd0;
      byte_sel   <= 1'b0;
      phase_cnt  <= 4'd0;
      gap_cnt    <= 8'd0;
      word_ready <= 1'b0;
      FU_D_out   <= 8'd0;
      FU_D_oe    <= 1'b0;
      FWR        <= 1'b1;
      busy       <= 1'b0;
      byte_count <= 32'd0;
    end else begin
      // A fresh word always gets one turnaround cycle before FTXE is trusted.
      if (state == STROBE && phase_cnt == PULSE_LAST) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == IDLE && accept) begin
        gap_cnt <= (gap_cnt > 8'd1) ? gap_cnt - 8'd1 : 8'd1;
      end else if (gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            word_reg   <= word_data;
            byte_sel   <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT_TXE;
          end else begin
            word_ready <= enable;
          end
        end
        WAIT_TXE: begin
          if (gap_cnt == 8'd0 && !txe_s) begin
            FU_D_out  <= byte_sel ? word_reg[15:8] : word_reg[7:0];
            FU_D_oe   <= 1'b1;
            phase_cnt <= 4'd0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            FWR       <= 1'b0;
            phase_cnt <= 4'd0;
            state     <= STROBE;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        STROBE: begin
          if (phase_cnt == PULSE_LAST) begin
            FWR        <= 1'b1;
            byte_count <= byte_count + 32'd1;
            phase_cnt  <= 4'd0;
            state      <= HOLD;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            FU_D_oe   <= 1'b0;
            phase_cnt <= 4'd0;
            if (byte_sel) begin
              busy       <= 1'b0;
              word_ready <= enable;
              state      <= IDLE;
            end else begin
              byte_sel <= 1'b1;
              state    <= WAIT_TXE;
            end
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: begin
          FWR        <= 1'b1;
          FU_D_oe    <= 1'b0;
          busy       <= 1'b0;
          word_ready <= 1'b0;
          phase_cnt  <= 4'd0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_tx_writer.sv
// Directed and randomised bench for ftdi_tx_writer; a byte-stream model and
// timing arithmetic provide every expected value.
module tb_ftdi_tx_writer;

  localparam int SETUP   = 1;
  localparam int PULSE   = 3;
  localparam int HOLD    = 1;
  localparam int GAP     = 4;
  localparam int SPACING = PULSE + ((GAP > HOLD + 1) ? GAP : HOLD + 1) + SETUP;

  logic        CLK48M = 1'b0;
  logic        RESET = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] word_data = 16'd0;
  logic        word_valid = 1'b0;
  logic        FTXE = 1'b0;
  logic        word_ready;
  logic [7:0]  FU_D_out;
  logic        FU_D_oe;
  logic        FWR;
  logic        busy;
  logic [31:0] byte_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int last_fall = 0;
  logic prev_fwr = 1'b1;
  logic prev_oe = 1'b0;
  logic [7:0] low_data = 8'd0;
  logic [31:0] exp_count = 32'd0;
  logic [7:0] exp_q[$];
  logic [7:0] byte_q[$];
  int fall_q[$];
  int width_q[$];
  int oe_rise_q[$];

  ftdi_tx_writer #(
    .SETUP_CYCLES(SETUP), .WR_PULSE_CYCLES(PULSE), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .CLK48M(CLK48M), .RESET(RESET), .enable(enable), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .FTXE(FTXE),
    .FU_D_out(FU_D_out), .FU_D_oe(FU_D_oe), .FWR(FWR), .busy(busy),
    .byte_count(byte_count)
  );

  always #5 CLK48M = ~CLK48M;

  always @(posedge CLK48M) cyc <= cyc + 1;

  // Pad monitor: records each written byte, strobe width and enable rise.
  always @(negedge CLK48M) begin
    if (prev_fwr && !FWR) begin
      fall_q.push_back(cyc);
      byte_q.push_back(FU_D_out);
      low_data  <= FU_D_out;
      last_fall <= cyc;
    end
    if (!prev_fwr && FWR) width_q.push_back(cyc - last_fall);
    if (!FWR && (!FU_D_oe || (!prev_fwr && FU_D_out != low_data))) viol <= viol + 1;
    if (!prev_oe && FU_D_oe) oe_rise_q.push_back(cyc);
    prev_fwr <= FWR;
    prev_oe  <= FU_D_oe;
  end

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_count = exp_count + 32'd2;
  endtask

  task automatic send_word(input logic [15:0] w, input bit hold, output int acc);
    int n = 0;
    word_data  = w;
    word_valid = 1'b1;
    while (word_ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(word_ready), 32'd1);
    tick();
    acc = cyc;
    if (!hold) word_valid = 1'b0;
    push_word(w);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_fwr(input logic level, input string tag);
    int n = 0;
    while (FWR !== level && n < 500) begin
      tick();
      n++;
    end
    chk(tag, 32'(FWR), 32'(level));
  endtask

  task automatic clear_obs();
    byte_q.delete();
    exp_q.delete();
    width_q.delete();
    fall_q.delete();
    oe_rise_q.delete();
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < byte_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(byte_q[i]), 32'(exp_q[i]));
    foreach (width_q[i]) chk({tag, "_pulse"}, 32'(width_q[i]), 32'(PULSE));
    chk({tag, "_count"}, byte_count, exp_count);
    clear_obs();
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int acc;
    int r;
    int sent;
    int n;
    bit acc_now;
    logic [15:0] w;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(word_ready), 32'd0);
    chk("rst_oe", 32'(FU_D_oe), 32'd0);
    chk("rst_fwr", 32'(FWR), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(FU_D_out), 32'd0);
    chk("rst_count", byte_count, 32'd0);
    RESET = 1'b1;
    repeat (3) tick();

    // Single word: 5A then A5, accept-to-strobe latency and spacing
    enable = 1'b1;
    send_word(16'hA55A, 1'b0, acc);
    wait_idle("w1_idle");
    chk("w1_oe_rise", 32'(at(oe_rise_q, 0)), 32'(acc + 2));
    chk("w1_fall0", 32'(at(fall_q, 0)), 32'(acc + 2 + SETUP));
    chk("w1_spacing", 32'(at(fall_q, 1) - at(fall_q, 0)), 32'(SPACING));
    check_bytes("w1");
    chk("w1_ready", 32'(word_ready), 32'd1);

    // Back-to-back stream with word_valid held high
    for (int k = 0; k < 4; k++) begin
      w = {8'(2 * k + 1), 8'(2 * k)};
      send_word(w, 1'b1, acc);
    end
    word_valid = 1'b0;
    wait_idle("str_idle");
    chk("str_nfalls", 32'(fall_q.size()), 32'd8);
    for (int i = 1; i < fall_q.size(); i++)
      chk("str_spacing", 32'(fall_q[i] - fall_q[i - 1]), 32'(SPACING));
    check_bytes("str");

    // FTXE full before accept, released later
    FTXE = 1'b1;
    repeat (3) tick();
    send_word(16'($urandom), 1'b0, acc);
    repeat (50) tick();
    chk("full_nbytes", 32'(byte_q.size()), 32'd0);
    chk("full_fwr", 32'(FWR), 32'd1);
    chk("full_oe", 32'(FU_D_oe), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    r = cyc;
    FTXE = 1'b0;
    wait_idle("full_idle");
    chk("full_oe_rise", 32'(at(oe_rise_q, 0)), 32'(r + 3));
    chk("full_fall", 32'(at(fall_q, 0)), 32'(r + 3 + SETUP));
    check_bytes("full");

    // FTXE rises during the low-byte strobe
    send_word(16'($urandom), 1'b0, acc);
    wait_fwr(1'b0, "mid_fwr_low");
    FTXE = 1'b1;
    repeat (20) tick();
    chk("mid_nbytes", 32'(byte_q.size()), 32'd1);
    chk("mid_oe", 32'(FU_D_oe), 32'd0);
    r = cyc;
    FTXE = 1'b0;
    wait_idle("mid_idle");
    chk("mid_fall", 32'(at(fall_q, 1)), 32'(r + 3 + SETUP));
    check_bytes("mid");

    // enable dropped after the low byte
    send_word(16'($urandom), 1'b0, acc);
    wait_fwr(1'b0, "en_fwr_low");
    wait_fwr(1'b1, "en_fwr_high");
    enable = 1'b0;
    wait_idle("en_idle");
    check_bytes("en");
    w = 16'($urandom);
    word_data  = w;
    word_valid = 1'b1;
    repeat (10) tick();
    chk("en_ready", 32'(word_ready), 32'd0);
    chk("en_nbytes", 32'(byte_q.size()), 32'd0);
    chk("en_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    send_word(w, 1'b0, acc);
    wait_idle("en2_idle");
    check_bytes("en2");

    // Reset during the strobe
    send_word(16'($urandom), 1'b0, acc);
    wait_fwr(1'b0, "rs_fwr_low");
    @(negedge CLK48M);
    #1;
    RESET = 1'b0;
    #1;
    chk("rs_fwr", 32'(FWR), 32'd1);
    chk("rs_oe", 32'(FU_D_oe), 32'd0);
    chk("rs_count", byte_count, 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    tick();
    repeat (3) tick();
    RESET = 1'b1;
    repeat (3) tick();
    clear_obs();
    exp_count = 32'd0;
    send_word(16'($urandom), 1'b0, acc);
    wait_idle("rs2_idle");
    check_bytes("rs2");

    // byte_count wrap
    force dut.byte_count = 32'hFFFF_FFFF;
    tick();
    release dut.byte_count;
    tick();
    exp_count = 32'hFFFF_FFFF;
    chk("wrap_pre", byte_count, exp_count);
    send_word(16'($urandom), 1'b0, acc);
    wait_fwr(1'b0, "wrap_fwr_low");
    wait_fwr(1'b1, "wrap_fwr_high");
    chk("wrap_zero", byte_count, exp_count - 32'd1);
    wait_idle("wrap_idle");
    check_bytes("wrap");

    // Randomised words with random FTXE back-pressure
    sent = 0;
    n = 0;
    while (sent < 12 && n < 6000) begin
      acc_now = word_valid && word_ready;
      if (acc_now) push_word(word_data);
      tick();
      n++;
      if (acc_now) begin
        word_valid = 1'b0;
        sent++;
      end
      if (!word_valid && sent < 12 && $urandom_range(0, 1) == 0) begin
        word_data  = 16'($urandom);
        word_valid = 1'b1;
      end
      FTXE = ($urandom_range(0, 3) == 0);
    end
    word_valid = 1'b0;
    FTXE = 1'b0;
    chk("rand_sent", 32'(sent), 32'd12);
    wait_idle("rand_idle");
    check_bytes("rand");
    chk("strobe_window", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
